// File: rtl/tile_pkg.sv
// ============================================================================
// Module  : tile_pkg
// Purpose : Shared types and constants for the tile output streamer.
//           - state_e       : streamer FSM states
//           - TILE_W_DEF     : default stream word width
//           - TILE_DEPTH_DEF : default words per tile (one BRAM half)
//           - sel_bit_pos()  : position of the half-select bit in a BRAM
//                              address, which equals the word-index width
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tile_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int TILE_W_DEF     = 16;
    localparam int TILE_DEPTH_DEF = 256;

    // The half-select bit sits directly above the word index.
    function automatic int sel_bit_pos(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_rd_fifo.sv
// ============================================================================
// Module  : tile_rd_fifo
// Purpose : Small synchronous FIFO that absorbs BRAM read latency in front of
//           the output stream. Depth need not be a power of two.
// Ports   : clk, rst (async, active-high)
//           i_push / i_din   write side
//           i_pop  / o_dout  read side (o_dout = head entry, stable until pop)
//           o_count, o_full, o_empty  occupancy status
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_rd_fifo #(
    parameter int DW     = 17,
    parameter int FDEPTH = 3,
    parameter int CW     = $clog2(FDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FDEPTH - 1);

    logic [DW-1:0] r_mem [FDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == CW'(FDEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FDEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/tile_stream_out.sv
// ============================================================================
// Module  : tile_stream_out
// Purpose : Reads a freshly loaded ping-pong BRAM half and streams its words
//           out as valid/ready with an end-of-tile marker, then releases the
//           half back to the loader. Read requests are credit-limited so the
//           output FIFO can always accept returning BRAM data.
// Ports   : clk, rst (async, active-high)
//           tile_ready/tile_sel       loader done pulse + filled half
//           bram_re/bram_raddr/bram_rdata  BRAM read port ({sel, index})
//           out_valid/out_ready/out_data/out_last  output stream
//           tile_free/tile_free_sel   half release pulse
//           busy, overrun             status (overrun is sticky)
//           perf_stall, perf_words    saturating counters, only with
//                                     TILE_STREAM_OUT_PERF_EN defined
// Config  : `define TILE_STREAM_OUT_PERF_EN adds the performance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_stream_out
    import tile_pkg::*;
#(
    parameter int W      = TILE_W_DEF,
    parameter int DEPTH  = TILE_DEPTH_DEF,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tile_ready,
    input  logic                       tile_sel,
    output logic                       bram_re,
    output logic [$clog2(2*DEPTH)-1:0] bram_raddr,
    input  logic [W-1:0]               bram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic                       out_last,
    output logic                       tile_free,
    output logic                       tile_free_sel,
    output logic                       busy,
    output logic                       overrun
`ifdef TILE_STREAM_OUT_PERF_EN
    ,
    output logic [31:0]                perf_stall,
    output logic [31:0]                perf_words
`endif
);

    localparam int IW     = sel_bit_pos(DEPTH);
    localparam int FDEPTH = RD_LAT + 2;
    localparam int CW     = $clog2(FDEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic            r_sel;
    logic [IW-1:0]   r_rd_idx;
    logic            r_pend_valid;
    logic            r_pend_sel;
    logic            r_overrun;
    logic [RD_LAT-1:0] r_vld_sr;
    logic [RD_LAT-1:0] r_last_sr;

    logic            w_start;
    logic            w_start_sel;
    logic            w_issue;
    logic            w_issue_last;
    logic            w_tile_free;
    logic            w_has_credit;
    logic [CW-1:0]   w_inflight;
    logic [CW:0]     w_credit_used;
    logic            w_push;
    logic            w_pop;
    logic [W:0]      w_fifo_dout;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_full;
    logic            w_fifo_empty;

    // ------------------------------------------------------------------
    // Credit: entries already in the FIFO plus reads still in the BRAM
    // pipeline may never exceed the FIFO depth, so a returning word always
    // finds a free slot regardless of back-pressure.
    // ------------------------------------------------------------------
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_vld_sr[i]);
        end
    end

    assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, w_inflight};
    assign w_has_credit  = (w_credit_used < (CW+1)'(FDEPTH));

    // A pending request has priority over a new pulse in the same cycle;
    // the new pulse then refills the pending slot.
    assign w_start_sel  = r_pend_valid ? r_pend_sel : tile_sel;
    assign w_issue_last = w_issue && (r_rd_idx == LAST_IDX);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_issue     = 1'b0;
        w_tile_free = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_valid || tile_ready) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (w_has_credit) begin
                    w_issue = 1'b1;
                    if (r_rd_idx == LAST_IDX) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Nothing in flight and FIFO empty means the last word popped.
                if ((w_inflight == '0) && w_fifo_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_tile_free = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read pointer, selected half, pending slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel        <= 1'b0;
            r_rd_idx     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_sel   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_start) begin
                r_sel    <= w_start_sel;
                r_rd_idx <= '0;
            end else if (w_issue) begin
                // Natural wrap returns the index to 0 after the last word.
                r_rd_idx <= r_rd_idx + IW'(1);
            end

            if (r_state == S_IDLE) begin
                if (r_pend_valid) begin
                    r_pend_valid <= tile_ready;
                    if (tile_ready) begin
                        r_pend_sel <= tile_sel;
                    end
                end
            end else if (tile_ready) begin
                if (r_pend_valid) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_sel   <= tile_sel;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Return path: track each read through the BRAM latency so its data is
    // pushed exactly when it appears on bram_rdata.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_sr  <= '0;
            r_last_sr <= '0;
        end else begin
            r_vld_sr  <= RD_LAT'({r_vld_sr, w_issue});
            r_last_sr <= RD_LAT'({r_last_sr, w_issue_last});
        end
    end

    assign w_push = r_vld_sr[RD_LAT-1];
    assign w_pop  = !w_fifo_empty && out_ready;

    tile_rd_fifo #(
        .DW     (W + 1),
        .FDEPTH (FDEPTH),
        .CW     (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({r_last_sr[RD_LAT-1], bram_rdata}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                    !(w_push && w_fifo_full));

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bram_re       = w_issue;
    assign bram_raddr    = {r_sel, r_rd_idx};
    assign out_valid     = !w_fifo_empty;
    assign out_data      = w_fifo_dout[W-1:0];
    assign out_last      = w_fifo_dout[W];
    assign tile_free     = w_tile_free;
    assign tile_free_sel = w_tile_free & r_sel;
    assign busy          = (r_state != S_IDLE) || r_pend_valid;
    assign overrun       = r_overrun;

`ifdef TILE_STREAM_OUT_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_words <= '0;
        end else begin
            if (out_valid && !out_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_pop && (r_perf_words != '1)) begin
                r_perf_words <= r_perf_words + 32'd1;
            end
        end
    end

    assign perf_stall = r_perf_stall;
    assign perf_words = r_perf_words;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tile_stream_out.sv
// ============================================================================
// Module  : tb_tile_stream_out
// Purpose : Self-checking bench for tile_stream_out. Instance A (DEPTH=8,
//           RD_LAT=1) runs a cycle table plus pending/overrun/reset
//           sequences; instance B (DEPTH=8, RD_LAT=3) runs under random
//           back-pressure. BRAM word at address a is 16'hA500 | a.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tile_stream_out;

    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
        return 16'hA500 | {12'h000, a};
    endfunction

    // ---------------- instance A ----------------
    logic          a_tile_ready = 1'b0, a_tile_sel = 1'b0, a_out_ready = 1'b1;
    logic          a_bram_re, a_out_valid, a_out_last, a_tile_free, a_tile_free_sel, a_busy, a_overrun;
    logic [AW-1:0] a_bram_raddr;
    logic [W-1:0]  a_bram_rdata, a_out_data, a_pipe;
    // ---------------- instance B ----------------
    logic          b_tile_ready = 1'b0, b_tile_sel = 1'b0, b_out_ready = 1'b1;
    logic          b_bram_re, b_out_valid, b_out_last, b_tile_free, b_tile_free_sel, b_busy, b_overrun;
    logic [AW-1:0] b_bram_raddr;
    logic [W-1:0]  b_bram_rdata, b_out_data;
    logic [W-1:0]  b_pipe [3];
`ifdef TILE_STREAM_OUT_PERF_EN
    logic [31:0]   a_perf_stall, a_perf_words, b_perf_stall, b_perf_words;
`endif

    tile_stream_out #(.W(W), .DEPTH(DEPTH), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .tile_ready(a_tile_ready), .tile_sel(a_tile_sel),
        .bram_re(a_bram_re), .bram_raddr(a_bram_raddr), .bram_rdata(a_bram_rdata),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .tile_free(a_tile_free), .tile_free_sel(a_tile_free_sel),
        .busy(a_busy), .overrun(a_overrun)
`ifdef TILE_STREAM_OUT_PERF_EN
        , .perf_stall(a_perf_stall), .perf_words(a_perf_words)
`endif
    );

    tile_stream_out #(.W(W), .DEPTH(DEPTH), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .tile_ready(b_tile_ready), .tile_sel(b_tile_sel),
        .bram_re(b_bram_re), .bram_raddr(b_bram_raddr), .bram_rdata(b_bram_rdata),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .tile_free(b_tile_free), .tile_free_sel(b_tile_free_sel),
        .busy(b_busy), .overrun(b_overrun)
`ifdef TILE_STREAM_OUT_PERF_EN
        , .perf_stall(b_perf_stall), .perf_words(b_perf_words)
`endif
    );

    // BRAM models: garbage when not read, so mistimed captures show up.
    always @(posedge clk) a_pipe <= a_bram_re ? mem_word(a_bram_raddr) : 16'hDEAD;
    assign a_bram_rdata = a_pipe;

    always @(posedge clk) begin
        b_pipe[0] <= b_bram_re ? mem_word(b_bram_raddr) : 16'hDEAD;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_bram_rdata = b_pipe[2];

    // ---------------- monitors ----------------
    logic [W:0] a_words[$];
    logic       a_frees[$];
    logic [W:0] b_words[$];
    logic       b_frees[$];
    logic [W:0] q_exp[$];
    logic       a_half_chk = 1'b0;
    logic       a_half_exp = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_half_chk && a_bram_re) chk("t2_addr_half", 32'(a_bram_raddr[AW-1]), 32'(a_half_exp));
            if (a_out_valid && a_out_ready) a_words.push_back({a_out_last, a_out_data});
            if (a_tile_free) a_frees.push_back(a_tile_free_sel);
        end
    end

    // Independent occupancy model for B: reads return 3 cycles after issue.
    logic [2:0] b_inf = '0;
    int         b_occ = 0;
    logic       b_prev_stall = 1'b0;
    logic [W:0] b_prev = '0;

    always @(posedge clk) begin
        if (rst) begin
            b_inf <= '0;
            b_occ <= 0;
        end else begin
            b_inf <= {b_inf[1:0], b_bram_re};
            b_occ <= b_occ + int'(b_inf[2]) - int'(b_out_valid && b_out_ready);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_bram_re) chk("t3_credit", 32'((b_occ + $countones(b_inf)) < 5), 32'd1);
            chk("t3_valid_model", 32'(b_out_valid), 32'(b_occ != 0));
            if (b_prev_stall) begin
                chk("t3_stall_valid", 32'(b_out_valid), 32'd1);
                chk("t3_stall_data", 32'({b_out_last, b_out_data}), 32'(b_prev));
            end
            b_prev_stall = b_out_valid && !b_out_ready;
            b_prev       = {b_out_last, b_out_data};
            if (b_out_valid && b_out_ready) b_words.push_back({b_out_last, b_out_data});
            if (b_tile_free) b_frees.push_back(b_tile_free_sel);
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_a(input logic sel);
        @(posedge clk); #1;
        a_tile_ready = 1'b1;
        a_tile_sel   = sel;
        @(posedge clk); #1;
        a_tile_ready = 1'b0;
    endtask

    task automatic wait_a_frees(input int n, input int budget, input string name);
        int k = 0;
        while (a_frees.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk({name, "_free_count"}, 32'(a_frees.size()), 32'(n));
    endtask

    task automatic add_tile(input logic sel);
        for (int i = 0; i < DEPTH; i++)
            q_exp.push_back({(i == DEPTH - 1), mem_word({sel, 3'(i)})});
    endtask

    task automatic check_a(input string name);
        chk({name, "_word_count"}, 32'(a_words.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < a_words.size(); i++)
            chk($sformatf("%s_w%0d", name, i), 32'(a_words[i]), 32'(q_exp[i]));
    endtask

    task automatic check_b(input string name);
        chk({name, "_word_count"}, 32'(b_words.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < b_words.size(); i++)
            chk($sformatf("%s_w%0d", name, i), 32'(b_words[i]), 32'(q_exp[i]));
    endtask

    typedef struct {
        logic        tr;
        logic        ts;
        logic        ordy;
        logic        e_re;
        logic [3:0]  e_addr;
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_last;
        logic        e_free;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic tr, input logic re, input logic [3:0] addr,
                                input logic vld, input logic [15:0] data, input logic last,
                                input logic free, input logic bsy);
        vec_t v;
        v.tr = tr; v.ts = 1'b0; v.ordy = 1'b1;
        v.e_re = re; v.e_addr = addr; v.e_vld = vld; v.e_data = data;
        v.e_last = last; v.e_free = free; v.e_busy = bsy;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[14];
        int   k;

        // Test 1 cycle table (DEPTH=8, RD_LAT=1, sel=0, out_ready=1).
        //             tr  re  addr  vld  data      last free busy
        vecs[0]  = mk(1, 0, 4'd0, 0, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(0, 1, 4'd0, 0, 16'h0000, 0, 0, 1);
        vecs[2]  = mk(0, 1, 4'd1, 0, 16'h0000, 0, 0, 1);
        vecs[3]  = mk(0, 1, 4'd2, 1, 16'hA500, 0, 0, 1);
        vecs[4]  = mk(0, 1, 4'd3, 1, 16'hA501, 0, 0, 1);
        vecs[5]  = mk(0, 1, 4'd4, 1, 16'hA502, 0, 0, 1);
        vecs[6]  = mk(0, 1, 4'd5, 1, 16'hA503, 0, 0, 1);
        vecs[7]  = mk(0, 1, 4'd6, 1, 16'hA504, 0, 0, 1);
        vecs[8]  = mk(0, 1, 4'd7, 1, 16'hA505, 0, 0, 1);
        vecs[9]  = mk(0, 0, 4'd0, 1, 16'hA506, 0, 0, 1);
        vecs[10] = mk(0, 0, 4'd0, 1, 16'hA507, 1, 0, 1);
        vecs[11] = mk(0, 0, 4'd0, 0, 16'h0000, 0, 0, 1);
        vecs[12] = mk(0, 0, 4'd0, 0, 16'h0000, 0, 1, 1);
        vecs[13] = mk(0, 0, 4'd0, 0, 16'h0000, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_re",      32'(a_bram_re),    32'd0);
        chk("rst_raddr",   32'(a_bram_raddr), 32'd0);
        chk("rst_valid",   32'(a_out_valid),  32'd0);
        chk("rst_free",    32'(a_tile_free),  32'd0);
        chk("rst_busy",    32'(a_busy),       32'd0);
        chk("rst_overrun", 32'(a_overrun),    32'd0);
        chk("rst_b_valid", 32'(b_out_valid),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: cycle-accurate table
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            a_tile_ready = vecs[i].tr;
            a_tile_sel   = vecs[i].ts;
            a_out_ready  = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("t1_re[%0d]", i), 32'(a_bram_re), 32'(vecs[i].e_re));
            if (vecs[i].e_re) chk($sformatf("t1_addr[%0d]", i), 32'(a_bram_raddr), 32'(vecs[i].e_addr));
            chk($sformatf("t1_valid[%0d]", i), 32'(a_out_valid), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) begin
                chk($sformatf("t1_data[%0d]", i), 32'(a_out_data), 32'(vecs[i].e_data));
                chk($sformatf("t1_last[%0d]", i), 32'(a_out_last), 32'(vecs[i].e_last));
            end
            chk($sformatf("t1_free[%0d]", i), 32'(a_tile_free), 32'(vecs[i].e_free));
            if (vecs[i].e_free) chk($sformatf("t1_free_sel[%0d]", i), 32'(a_tile_free_sel), 32'd0);
            chk($sformatf("t1_busy[%0d]", i), 32'(a_busy), 32'(vecs[i].e_busy));
        end

        // Test 2: upper half only
        a_words.delete(); a_frees.delete(); q_exp.delete();
        a_half_exp = 1'b1;
        a_half_chk = 1'b1;
        pulse_a(1'b1);
        wait_a_frees(1, 60, "t2");
        a_half_chk = 1'b0;
        add_tile(1'b1);
        check_a("t2");
        if (a_frees.size() >= 1) chk("t2_free_sel", 32'(a_frees[0]), 32'd1);

        // Test 3: RD_LAT=3 with random back-pressure, two tiles (second pending)
        b_words.delete(); b_frees.delete(); q_exp.delete();
        for (int c = 0; c < 600 && b_frees.size() < 2; c++) begin
            @(posedge clk); #1;
            b_tile_ready = (c == 0 || c == 3);
            b_tile_sel   = (c == 3);
            b_out_ready  = 1'($urandom_range(0, 1));
        end
        b_tile_ready = 1'b0;
        b_out_ready  = 1'b1;
        chk("t3_free_count", 32'(b_frees.size()), 32'd2);
        add_tile(1'b0);
        add_tile(1'b1);
        check_b("t3");
        if (b_frees.size() >= 2) begin
            chk("t3_free0", 32'(b_frees[0]), 32'd0);
            chk("t3_free1", 32'(b_frees[1]), 32'd1);
        end
        chk("t3_overrun", 32'(b_overrun), 32'd0);

        // Test 4: request mid-tile goes to pending
        a_words.delete(); a_frees.delete(); q_exp.delete();
        pulse_a(1'b0);
        repeat (3) @(posedge clk);
        pulse_a(1'b1);
        wait_a_frees(2, 100, "t4");
        repeat (3) @(posedge clk);
        add_tile(1'b0);
        add_tile(1'b1);
        check_a("t4");
        if (a_frees.size() >= 2) begin
            chk("t4_free0", 32'(a_frees[0]), 32'd0);
            chk("t4_free1", 32'(a_frees[1]), 32'd1);
        end
        chk("t4_overrun", 32'(a_overrun), 32'd0);
        chk("t4_busy",    32'(a_busy),    32'd0);

        // Test 5: three requests during one tile -> one pending, overrun
        a_words.delete(); a_frees.delete(); q_exp.delete();
        pulse_a(1'b0);
        repeat (2) @(posedge clk);
        pulse_a(1'b1);
        pulse_a(1'b0);
        pulse_a(1'b1);
        wait_a_frees(2, 100, "t5");
        repeat (20) @(posedge clk);
        add_tile(1'b0);
        add_tile(1'b1);
        check_a("t5");
        chk("t5_tiles",   32'(a_frees.size()), 32'd2);
        chk("t5_overrun", 32'(a_overrun),      32'd1);
        chk("t5_busy",    32'(a_busy),         32'd0);

        // Test 6: reset at word 4
        a_words.delete(); a_frees.delete(); q_exp.delete();
        pulse_a(1'b0);
        k = 0;
        while (a_words.size() < 4 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t6_reached_word4", 32'(a_words.size() >= 4), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_re",      32'(a_bram_re),    32'd0);
        chk("t6_rst_raddr",   32'(a_bram_raddr), 32'd0);
        chk("t6_rst_valid",   32'(a_out_valid),  32'd0);
        chk("t6_rst_data",    32'(a_out_data),   32'd0);
        chk("t6_rst_last",    32'(a_out_last),   32'd0);
        chk("t6_rst_busy",    32'(a_busy),       32'd0);
        chk("t6_rst_overrun", 32'(a_overrun),    32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t6_rst_free[%0d]", i), 32'(a_tile_free), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("t6_no_free", 32'(a_frees.size()), 32'd0);
        a_words.delete();
        pulse_a(1'b0);
        wait_a_frees(1, 60, "t6");
        add_tile(1'b0);
        check_a("t6");
        if (a_frees.size() >= 1) chk("t6_free_sel", 32'(a_frees[0]), 32'd0);
        chk("t6_overrun", 32'(a_overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
